// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Turns a decoded instruction request (class, ALU operation, funct3, register
// fields, immediate) into a 32-bit RV32I machine word. A single output register
// stage gives one-cycle latency, and back-to-back requests stream with no
// bubble. Illegal requests park the block in an error state until clr_err. A
// byte-address counter tags each emitted word with its instruction-memory
// address.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   encode request present
//   in_ready   request accepted when in_valid && in_ready at a clock edge
//   op_class   0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE,
//              7 R, 8 IMM; 9-15 illegal
//   alu_ctl    ALU operation for R/IMM classes
//   funct3     condition/width for BRANCH/LOAD/STORE
//   rs1/rs2/rd register fields
//   imm        signed immediate (U-type uses imm[31:12])
//   out_valid  encoded word available
//   out_ready  downstream takes the word when out_valid && out_ready
//   out_instr  encoded RV32I word
//   out_addr   byte address of out_instr
//   base_addr  counter load value (word aligned on load)
//   load_base  load the address counter, wins over increment
//   err        high while in the error state
//   clr_err    leaves the error state
// -----------------------------------------------------------------------------
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_class,
    input  logic [3:0]  alu_ctl,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    input  logic [31:0] base_addr,
    input  logic        load_base,
    output logic        err,
    input  logic        clr_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [3:0] ALU_SUB   = 4'b0110;

    state_t      state, state_nxt;
    logic        accept;
    logic        xfer;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic [31:0] base_aligned;

    // ALU operation decode
    logic [2:0]  alu_f3;
    logic        alu_alt;     // funct7 = 0100000 (SUB, SRA)
    logic        alu_known;
    logic        alu_shift;   // shift-immediate form for IMM class

    // Immediate range checks: upper bits must be a pure sign extension.
    logic imm_i_ok, imm_b_ok, imm_j_ok, imm_u_ok, imm_sh_ok;

    assign imm_i_ok  = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm_b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign imm_j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    assign imm_u_ok  = ~(|imm[11:0]);
    assign imm_sh_ok = ~(|imm[31:5]);

    assign base_aligned = base_addr & 32'hFFFF_FFFC;

    assign in_ready  = (state == ST_EMPTY) || ((state == ST_HOLD) && out_ready);
    assign out_valid = (state == ST_HOLD);
    assign err       = (state == ST_ERR);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_f3    = 3'b000;
        alu_alt   = 1'b0;
        alu_known = 1'b1;
        alu_shift = 1'b0;
        unique case (alu_ctl)
            4'b0000: alu_f3 = 3'b111;                               // AND
            4'b0001: alu_f3 = 3'b110;                               // OR
            4'b0010: alu_f3 = 3'b000;                               // ADD
            4'b0011: alu_f3 = 3'b010;                               // SLT
            4'b0100: begin alu_f3 = 3'b101; alu_shift = 1'b1; end   // SRL
            4'b0101: begin alu_f3 = 3'b001; alu_shift = 1'b1; end   // SLL
            4'b0110: begin alu_f3 = 3'b000; alu_alt = 1'b1; end     // SUB
            4'b0111: alu_f3 = 3'b011;                               // SLTU
            4'b1000: begin                                          // SRA
                alu_f3    = 3'b101;
                alu_alt   = 1'b1;
                alu_shift = 1'b1;
            end
            4'b1100: alu_f3 = 3'b100;                               // XOR
            default: alu_known = 1'b0;
        endcase
    end

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        case (op_class)
            4'd0: begin
                enc_word  = {imm[31:12], rd, OP_LUI};
                enc_legal = imm_u_ok;
            end
            4'd1: begin
                enc_word  = {imm[31:12], rd, OP_AUIPC};
                enc_legal = imm_u_ok;
            end
            4'd2: begin
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                enc_legal = imm_j_ok;
            end
            4'd3: begin
                enc_word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                enc_legal = imm_i_ok;
            end
            4'd4: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], OP_BRANCH};
                enc_legal = imm_b_ok && (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            4'd5: begin
                enc_word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                enc_legal = imm_i_ok && (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            4'd6: begin
                enc_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                enc_legal = imm_i_ok && (funct3 <= 3'b010);
            end
            4'd7: begin
                enc_word  = {1'b0, alu_alt, 5'b0, rs2, rs1, alu_f3, rd, OP_R};
                enc_legal = alu_known;
            end
            4'd8: begin
                // Shift-immediates carry funct7 above a 5-bit shamt; the rest
                // use a plain 12-bit immediate. SUB has no immediate form.
                if (alu_shift) begin
                    enc_word  = {1'b0, alu_alt, 5'b0, imm[4:0], rs1, alu_f3, rd, OP_IMM};
                    enc_legal = alu_known && imm_sh_ok;
                end else begin
                    enc_word  = {imm[11:0], rs1, alu_f3, rd, OP_IMM};
                    enc_legal = alu_known && (alu_ctl != ALU_SUB) && imm_i_ok;
                end
            end
            default: begin
                enc_word  = 32'h0;
                enc_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (accept) state_nxt = enc_legal ? ST_HOLD : ST_ERR;
            end
            ST_HOLD: begin
                if (accept)         state_nxt = enc_legal ? ST_HOLD : ST_ERR;
                else if (out_ready) state_nxt = ST_EMPTY;
            end
            ST_ERR: begin
                // in_ready is low here, so a request in the clr_err cycle is dropped.
                if (clr_err) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_EMPTY;
            out_instr <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept && enc_legal) out_instr <= enc_word;
        end
    end

    // A word counts as emitted when it leaves, including the cycle an illegal
    // request is accepted behind it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         out_addr <= 32'h0;
        else if (load_base) out_addr <= base_aligned;
        else if (xfer)      out_addr <= out_addr + 32'd4;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder: reset behaviour, single and streamed
// encodes with hand-computed words, stalls, illegal requests and error
// recovery, address counter load/wrap and asynchronous reset in HOLD.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_class;
    logic [3:0]  alu_ctl;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [31:0] base_addr;
    logic        load_base;
    logic        err;
    logic        clr_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_addr;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  d;
        logic [31:0] im;
        logic [31:0] word;
    } vec_t;

    vec_t legal_q[$];
    vec_t illegal_q[$];

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_class  (op_class),
        .alu_ctl   (alu_ctl),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .base_addr (base_addr),
        .load_base (load_base),
        .err       (err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input vec_t v);
        in_valid = 1'b1;
        op_class = v.op;
        alu_ctl  = v.alu;
        funct3   = v.f3;
        rs1      = v.s1;
        rs2      = v.s2;
        rd       = v.d;
        imm      = v.im;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    vec_t v_add, v_sub, v_addi_m1, v_beq;

    initial begin
        //            op     alu      f3      rs1    rs2    rd     imm            word
        v_add     = '{4'd7, 4'b0010, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0,        32'h002081B3};
        v_sub     = '{4'd7, 4'b0110, 3'd0, 5'd6, 5'd7, 5'd5, 32'h0,        32'h407302B3};
        v_addi_m1 = '{4'd8, 4'b0010, 3'd0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 32'hFFF00093};
        v_beq     = '{4'd4, 4'b0000, 3'd0, 5'd1, 5'd2, 5'd0, 32'd8,        32'h00208463};

        legal_q.push_back('{4'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd5,  32'h12345000, 32'h123452B7}); // lui
        legal_q.push_back('{4'd1, 4'd0, 3'd0, 5'd0, 5'd0, 5'd1,  32'h00001000, 32'h00001097}); // auipc
        legal_q.push_back('{4'd2, 4'd0, 3'd0, 5'd0, 5'd0, 5'd1,  32'd8,        32'h008000EF}); // jal
        legal_q.push_back('{4'd3, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0,  32'd0,        32'h00008067}); // jalr
        legal_q.push_back('{4'd5, 4'd0, 3'd2, 5'd2, 5'd0, 5'd10, 32'd4,        32'h00412503}); // lw
        legal_q.push_back('{4'd6, 4'd0, 3'd2, 5'd2, 5'd10, 5'd0, 32'd8,        32'h00A12423}); // sw
        legal_q.push_back('{4'd6, 4'd0, 3'd0, 5'd6, 5'd5, 5'd0,  32'hFFFFFFFF, 32'hFE530FA3}); // sb -1
        legal_q.push_back('{4'd4, 4'd0, 3'd1, 5'd1, 5'd0, 5'd0,  32'hFFFFFFFC, 32'hFE009EE3}); // bne -4
        legal_q.push_back('{4'd8, 4'b1000, 3'd0, 5'd1, 5'd0, 5'd1, 32'd3,      32'h4030D093}); // srai
        legal_q.push_back('{4'd8, 4'b0101, 3'd0, 5'd3, 5'd0, 5'd2, 32'd31,     32'h01F19113}); // slli
        legal_q.push_back('{4'd7, 4'b1100, 3'd0, 5'd5, 5'd6, 5'd4, 32'd0,      32'h0062C233}); // xor
        legal_q.push_back('{4'd7, 4'b1000, 3'd0, 5'd2, 5'd3, 5'd1, 32'd0,      32'h403150B3}); // sra
        legal_q.push_back('{4'd7, 4'b0001, 3'd0, 5'd2, 5'd3, 5'd1, 32'd0,      32'h003160B3}); // or

        illegal_q.push_back('{4'd8, 4'b0110, 3'd0, 5'd1, 5'd0, 5'd1, 32'd1,    32'h0}); // addi as sub
        illegal_q.push_back('{4'd8, 4'b0010, 3'd0, 5'd1, 5'd0, 5'd1, 32'd2048, 32'h0}); // imm too big
        illegal_q.push_back('{4'd9, 4'b0010, 3'd0, 5'd1, 5'd0, 5'd1, 32'd0,    32'h0}); // class 9
        illegal_q.push_back('{4'd7, 4'b1001, 3'd0, 5'd1, 5'd2, 5'd1, 32'd0,    32'h0}); // alu 1001
        illegal_q.push_back('{4'd4, 4'd0,    3'd2, 5'd1, 5'd2, 5'd0, 32'd8,    32'h0}); // branch f3 010
        illegal_q.push_back('{4'd5, 4'd0,    3'd6, 5'd1, 5'd0, 5'd1, 32'd0,    32'h0}); // load f3 110
        illegal_q.push_back('{4'd6, 4'd0,    3'd3, 5'd1, 5'd2, 5'd0, 32'd0,    32'h0}); // store f3 011
        illegal_q.push_back('{4'd2, 4'd0,    3'd0, 5'd0, 5'd0, 5'd1, 32'd3,    32'h0}); // jal odd
        illegal_q.push_back('{4'd4, 4'd0,    3'd0, 5'd1, 5'd2, 5'd0, 32'd4096, 32'h0}); // branch range
        illegal_q.push_back('{4'd0, 4'd0,    3'd0, 5'd0, 5'd0, 5'd1, 32'h00000800, 32'h0}); // lui low bits
        illegal_q.push_back('{4'd8, 4'b0101, 3'd0, 5'd1, 5'd0, 5'd1, 32'd32,   32'h0}); // slli shamt 32

        // ---- reset, with noise on inputs that must be ignored ----
        reset     = 1'b0;
        out_ready = 1'b0;
        base_addr = 32'h0000_1234;
        load_base = 1'b1;
        clr_err   = 1'b1;
        req(v_add);
        repeat (2) step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr",  out_addr,  32'h0);
        check("rst_err",       {31'b0, err}, 32'd0);
        idle();
        load_base = 1'b0;
        clr_err   = 1'b0;
        #2 reset  = 1'b1;
        step();
        check("rel_in_ready",  {31'b0, in_ready},  32'd1);
        check("rel_out_valid", {31'b0, out_valid}, 32'd0);
        exp_addr = 32'h0;

        // ---- single encode, latency 1 ----
        req(v_add);
        step();
        idle();
        check("add_valid",    {31'b0, out_valid}, 32'd1);
        check("add_instr",    out_instr, v_add.word);
        check("add_addr",     out_addr,  exp_addr);
        check("add_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1 check("add_in_ready_or", {31'b0, in_ready}, 32'd1);
        step();
        exp_addr += 4;
        check("add_done_valid", {31'b0, out_valid}, 32'd0);
        check("add_done_addr",  out_addr, exp_addr);

        // ---- back-to-back stream, no bubble ----
        load_base = 1'b1;
        base_addr = 32'h0;
        step();
        load_base = 1'b0;
        exp_addr  = 32'h0;
        check("ld0_addr", out_addr, exp_addr);
        req(v_sub);
        step();
        check("sub_instr", out_instr, v_sub.word);
        check("sub_addr",  out_addr,  exp_addr);
        req(v_addi_m1);
        step();
        exp_addr += 4;
        check("addi_valid", {31'b0, out_valid}, 32'd1);
        check("addi_instr", out_instr, v_addi_m1.word);
        check("addi_addr",  out_addr,  exp_addr);
        idle();
        step();
        exp_addr += 4;
        check("stream_end_valid", {31'b0, out_valid}, 32'd0);
        check("stream_end_addr",  out_addr, exp_addr);

        // ---- stall: word and address held ----
        out_ready = 1'b0;
        req(v_beq);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            check("stall_valid",    {31'b0, out_valid}, 32'd1);
            check("stall_instr",    out_instr, v_beq.word);
            check("stall_addr",     out_addr,  exp_addr);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        exp_addr += 4;
        check("stall_done_addr", out_addr, exp_addr);

        // ---- encoding table, streamed ----
        for (int i = 0; i <= legal_q.size(); i++) begin
            if (i > 0) begin
                check($sformatf("enc%0d_instr", i - 1), out_instr, legal_q[i - 1].word);
                check($sformatf("enc%0d_addr",  i - 1), out_addr,  exp_addr);
                exp_addr += 4;
            end
            if (i < legal_q.size()) req(legal_q[i]);
            else                    idle();
            step();
        end
        check("enc_end_valid", {31'b0, out_valid}, 32'd0);
        check("enc_end_addr",  out_addr, exp_addr);

        // ---- illegal requests and recovery ----
        for (int i = 0; i < illegal_q.size(); i++) begin
            req(illegal_q[i]);
            step();
            idle();
            check($sformatf("ill%0d_err", i),      {31'b0, err},       32'd1);
            check($sformatf("ill%0d_valid", i),    {31'b0, out_valid}, 32'd0);
            check($sformatf("ill%0d_in_ready", i), {31'b0, in_ready},  32'd0);
            req(v_add);          // must be ignored in the clr_err cycle
            clr_err = 1'b1;
            step();
            clr_err = 1'b0;
            idle();
            check($sformatf("clr%0d_err", i),   {31'b0, err},       32'd0);
            check($sformatf("clr%0d_valid", i), {31'b0, out_valid}, 32'd0);
            check($sformatf("clr%0d_ready", i), {31'b0, in_ready},  32'd1);
            check($sformatf("clr%0d_addr", i),  out_addr, exp_addr);
        end

        // ---- illegal accepted while a held word completes ----
        out_ready = 1'b0;
        req(v_add);
        step();
        out_ready = 1'b1;
        req(illegal_q[0]);
        step();
        idle();
        exp_addr += 4;
        check("hold_ill_err",   {31'b0, err}, 32'd1);
        check("hold_ill_valid", {31'b0, out_valid}, 32'd0);
        check("hold_ill_addr",  out_addr, exp_addr);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // ---- counter load, priority and wrap ----
        load_base = 1'b1;
        base_addr = 32'h0000_0FFE;
        step();
        load_base = 1'b0;
        check("load_align", out_addr, 32'h0000_0FFC);
        out_ready = 1'b0;
        req(v_add);
        step();
        idle();
        out_ready = 1'b1;
        load_base = 1'b1;
        base_addr = 32'h0000_0100;
        step();
        check("load_prio", out_addr, 32'h0000_0100);
        base_addr = 32'hFFFF_FFFF;
        step();
        load_base = 1'b0;
        check("load_top", out_addr, 32'hFFFF_FFFC);
        req(v_sub);
        step();
        idle();
        check("wrap_pre", out_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr", out_addr, 32'h0);

        // ---- asynchronous reset while holding ----
        out_ready = 1'b0;
        req(v_beq);
        step();
        idle();
        check("arst_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_addr",  out_addr,  32'h0);
        check("arst_instr", out_instr, 32'h0);
        #3 reset = 1'b1;
        step();
        check("arst_rel_ready", {31'b0, in_ready},  32'd1);
        check("arst_rel_valid", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
